// File: rtl/multi_input_capture.sv
// rtl/multi_input_capture.sv - multi-channel input capture timer with shared timebase
//
// Purpose:
//   A free-running CW-bit timebase shared by CH capture channels. Each channel
//   synchronizes its asynchronous input and detects rising, falling or both
//   edges. On a qualified edge it latches the timebase into its capture
//   register and raises a pending flag. A capture that arrives while the
//   pending flag is still set raises an overrun flag.
//
// Ports:
//   clk       - single clock, rising-edge
//   rst       - synchronous active-low reset
//   en        - timebase count enable and capture enable
//   sig       - [CH-1:0] asynchronous capture inputs
//   edge_sel  - [2*CH-1:0] per-channel mode: 00 off, 01 rise, 10 fall, 11 both
//   clr_val   - [CH-1:0] per-channel clear of the capture register
//   clr_flag  - [CH-1:0] per-channel clear of int_flag / ovf_flag
//   count     - [CW-1:0] timebase value
//   val       - [CH*CW-1:0] capture registers, channel i at [i*CW +: CW]
//   int_flag  - [CH-1:0] capture pending
//   ovf_flag  - [CH-1:0] capture overrun
//   irq       - registered OR of all int_flag and ovf_flag bits

module multi_input_capture #(
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CH-1:0]    sig,
  input  logic [2*CH-1:0]  edge_sel,
  input  logic [CH-1:0]    clr_val,
  input  logic [CH-1:0]    clr_flag,
  output logic [CW-1:0]    count,
  output logic [CH*CW-1:0] val,
  output logic [CH-1:0]    int_flag,
  output logic [CH-1:0]    ovf_flag,
  output logic             irq
);

  // synchronizer, history and registered edge qualifier
  logic [CH-1:0] sync1;
  logic [CH-1:0] sync2;
  logic [CH-1:0] hist;
  logic [CH-1:0] edge_q;

  // counts clocks since reset release; edges are ignored until it saturates
  logic [1:0]    arm;
  logic          armed;

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] val_r [CH];
  logic [CH-1:0] int_r;
  logic [CH-1:0] ovf_r;
  logic          irq_r;

  logic [CH-1:0] det;
  logic [CH-1:0] cap;

  assign armed = (arm == 2'd3);

  // Edge detection compares the synchronized level with the history flop.
  // The result is registered into edge_q, so the capture happens one cycle
  // later using the timebase value present in that capture cycle. This
  // gives three clocks from the first sampling edge to the register update.
  always_comb begin
    det = '0;
    cap = '0;
    for (int i = 0; i < CH; i++) begin
      det[i] = (edge_sel[2*i]   &  sync2[i] & ~hist[i]) |
               (edge_sel[2*i+1] & ~sync2[i] &  hist[i]);
      cap[i] = edge_q[i] & en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      hist   <= '0;
      edge_q <= '0;
      arm    <= 2'd0;
      cnt_r  <= '0;
      int_r  <= '0;
      ovf_r  <= '0;
      irq_r  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        val_r[i] <= '0;
      end
    end else begin
      // the input pipeline keeps tracking sig even while en=0, so a level
      // change during a disabled window is absorbed rather than replayed
      sync1 <= sig;
      sync2 <= sync1;
      hist  <= sync2;

      if (!armed) begin
        arm <= arm + 2'd1;
      end

      edge_q <= det & {CH{armed & en}};

      if (en) begin
        cnt_r <= cnt_r + CW'(1);
      end

      for (int i = 0; i < CH; i++) begin
        if (cap[i]) begin
          // capture wins over a coincident flag clear; overrun only when a
          // pending capture was not being acknowledged in the same cycle
          int_r[i] <= 1'b1;
          ovf_r[i] <= int_r[i] & ~clr_flag[i];
        end else if (clr_flag[i]) begin
          int_r[i] <= 1'b0;
          ovf_r[i] <= 1'b0;
        end

        // a value clear overrides the timestamp but not the flag effects
        if (clr_val[i]) begin
          val_r[i] <= '0;
        end else if (cap[i]) begin
          val_r[i] <= cnt_r;
        end
      end

      irq_r <= (|int_r) | (|ovf_r);
    end
  end

  assign count    = cnt_r;
  assign int_flag = int_r;
  assign ovf_flag = ovf_r;
  assign irq      = irq_r;

  for (genvar g = 0; g < CH; g++) begin : g_val
    assign val[g*CW +: CW] = val_r[g];
  end

endmodule

// File: doc/multi_input_capture.md
MULTI_INPUT_CAPTURE -- requirements
Module: multi_input_capture

Interface
REQ-001 SHALL have parameter CH, default 4, number of capture channels (1..16).
REQ-002 SHALL have parameter CW, default 16, timebase and capture-register width (4..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  input  1  timebase count enable and capture enable.
REQ-006 SHALL have port sig  input  CH  asynchronous capture inputs, one bit per channel.
REQ-007 SHALL have port edge_sel  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port clr_val  input  CH  per-channel clear of the capture register.
REQ-009 SHALL have port clr_flag  input  CH  per-channel clear of int_flag and ovf_flag.
REQ-010 SHALL have port count  output  CW  free-running timebase value.
REQ-011 SHALL have port val  output  CH*CW  capture registers; channel i occupies [i*CW+CW-1:i*CW].
REQ-012 SHALL have port int_flag  output  CH  per-channel capture-pending flag.
REQ-013 SHALL have port ovf_flag  output  CH  per-channel overrun flag.
REQ-014 SHALL have port irq  output  1  registered OR of all int_flag and ovf_flag bits.

Function
REQ-015 SHALL increment count by 1 on each clock with en=1, hold it with en=0, and wrap from 2^CW-1 to 0 without a flag.
REQ-016 SHALL pass each sig bit through a 2-flop synchronizer, then a third history flop used for edge detection.
REQ-017 SHALL detect an edge on channel i when the synchronized value differs from the history flop in the direction selected by edge_sel.
REQ-018 SHALL ignore sig edges in the first 3 clocks after rst is released, so a level present at reset yields no capture.
REQ-019 SHALL, on a detected edge with en=1 and mode not 00, load val[i] with the count value present in that cycle and set int_flag[i], both at the next edge.
REQ-020 SHALL give a latency of exactly 3 clocks from the first clk edge sampling the new sig level to val/int_flag updating.
REQ-021 SHALL, on a capture while int_flag[i]=1 and clr_flag[i]=0, overwrite val[i] with the newest timestamp and set ovf_flag[i].
REQ-022 SHALL suppress captures with en=0 while the synchronizer and history flops keep tracking sig, so re-enabling never creates a stale edge.
REQ-023 SHALL, on clr_flag[i]=1 without a capture, clear int_flag[i] and ovf_flag[i] at the next edge.
REQ-024 SHALL, on clr_flag[i] and a capture in the same cycle, give the capture priority: int_flag[i]=1, ovf_flag[i]=0, val[i] updated.
REQ-025 SHALL, on clr_val[i]=1, load val[i] with 0, even when a capture occurs in the same cycle, while still applying the capture's flag effects.
REQ-026 SHALL make channels fully independent; simultaneous edges on several channels SHALL all capture the same count value.
REQ-027 SHALL update irq one clock after any flag change.

Reset
REQ-028 SHALL, while rst=0 at a clk edge, load count, val, int_flag, ovf_flag, irq, the synchronizer and history flops, and the arm counter with 0.
REQ-029 SHALL give rst priority over en, sig, clr_val and clr_flag, and SHALL abort any in-flight edge on reset mid-operation.

Verification
REQ-030 SHALL cover: rst released, en=1, ch0 rising mode, sig[0] rises sampled at edge 10 -> val[0]=count value in cycle 12, int_flag[0]=1 and irq=1 after edges 13 and 14.
REQ-031 SHALL cover: two ch1 captures without clr_flag -> val[1]=second timestamp, ovf_flag[1]=1; then clr_flag[1] pulse -> both flags 0, irq 0 one clock later.
REQ-032 SHALL cover: CW=4, en=1 for 20 clocks -> count wraps 15->0, capture after wrap holds the small post-wrap value.
REQ-033 SHALL cover: clr_flag[2] coincident with a capture -> int_flag[2]=1, ovf_flag[2]=0; clr_val[2] coincident with a capture -> val[2]=0, int_flag[2]=1.
REQ-034 SHALL cover: sig high through reset -> no capture; en=0 during a pulse on ch3 in both-edge mode, then en=1 -> no capture, count frozen during en=0.
REQ-035 SHALL cover: identical rising edge on all channels -> all val slices equal; rst asserted mid-pipeline -> all outputs 0, no capture afterwards.
